branch_cond_unit: RTL and testbench
===================================

Name: branch_cond_unit

Overview:
- Consumer side of the 4-bit processor status flags. Accepts a branch request (condition code + target), reads the current flags, evaluates the condition and returns a registered taken/not-taken result with the target.
- Stalls while an in-flight multi-cycle ALU operation is still due to update the flags.
- Forwards flags being loaded in the same cycle, so the result never uses stale flags.
- Sits between the decode/issue stage and the PC update logic.

Parameters:
- ADDR_W, 16, width of branch target address
- WAIT_MAX, 15, maximum cycles spent waiting on flags_pending before an error response (1..255)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- status  in  4  registered flags {N,Z,C,V} = status[3:0]
- status_load  in  1  flags register loads status_in this cycle
- status_in  in  4  flag value being loaded (same encoding)
- flags_pending  in  1  an issued op will still write flags; evaluation must wait
- req_valid  in  1  branch request valid
- req_ready  out  1  unit can accept a request
- req_cond  in  4  condition code
- req_target  in  ADDR_W  branch target
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer accepts result
- resp_taken  out  1  condition true
- resp_err  out  1  flag wait timed out; resp_taken forced 0
- resp_target  out  ADDR_W  target of the resolved request

Behaviour:
- Reset (rst=0, async): state IDLE; resp_valid, resp_taken, resp_err = 0; resp_target = 0; wait counter = 0; req_ready = 0 while in reset.
- Effective flags eff = status_load ? status_in : status (combinational bypass). Evaluation always uses eff in the evaluating cycle.
- Condition codes:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - 10 GE: N==V
  - 11 LT: N!=V
  - 12 GT: !Z&(N==V)
  - 13 LE: Z|(N!=V)
  - 14 AL: 1
  - 15 NV: 0
- State IDLE:
  - req_ready = 1. Handshake on req_valid&req_ready; req_cond and req_target are captured.
  - If flags_pending=0 at acceptance: evaluate with eff, go to RESP. resp_valid=1 in the next cycle (1-cycle latency).
  - If flags_pending=1: go to WAIT with counter = 0.
- State WAIT:
  - req_ready = 0.
  - Each cycle with flags_pending=0: evaluate the held cond with eff, go to RESP, resp_err=0. An update with status_load=1 in that same cycle is honoured via the bypass.
  - Else the counter increments. When counter == WAIT_MAX-1 and flags_pending is still 1: go to RESP with resp_err=1 and resp_taken=0.
- State RESP:
  - resp_valid = 1; outputs are held stable until resp_ready=1.
  - On resp_ready: go to IDLE and clear resp_valid next cycle. req_ready is 0 in RESP; there is no back-to-back overlap, so max throughput is 1 request per 2 cycles.
- resp_target and resp_taken update only on evaluation; they are unchanged otherwise.
- Flag changes after evaluation do not alter a pending response.
- Reset asserted mid-operation discards the held request and any pending response immediately.
- Counter width is ceil(log2(WAIT_MAX+1)); it never wraps, because the state leaves WAIT at the limit.

Test Plan:
- Reset with rst=0 mid-WAIT → resp_valid=0, req_ready=0 during reset, IDLE after release; next request behaves normally.
- status=4'b0100 (Z=1), req_cond=0 (EQ), req_target=16'h1234, flags_pending=0, resp_ready=1 → one cycle later resp_valid=1, resp_taken=1, resp_target=16'h1234, resp_err=0.
- status=4'b0000, status_load=1, status_in=4'b1000 in the accept cycle, req_cond=4 (MI) → resp_taken=1 (bypass used).
- flags_pending=1 for 3 cycles after accept, then 0 with status_load=1, status_in=4'b1001, req_cond=10 (GE) → WAIT for 3 cycles, then resp_taken=1 (N==V), resp_err=0.
- flags_pending held at 1, WAIT_MAX=15 → resp_valid rises after 15 WAIT cycles with resp_err=1, resp_taken=0.
- resp_ready=0 for 4 cycles while status changes → resp_valid, resp_taken and resp_target stay constant and req_ready=0; after resp_ready=1, IDLE and req_ready=1 next cycle. Sweep all 16 cond codes against all 16 flag values.

Source files
------------

// File: rtl/branch_cond_unit.sv
// Branch condition resolver: evaluates a condition code against the processor
// flags (with same-cycle load bypass) and returns a registered taken/target result.
module branch_cond_unit #(
  parameter int ADDR_W   = 16,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        status,
  input  logic              status_load,
  input  logic [3:0]        status_in,
  input  logic              flags_pending,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_cond,
  input  logic [ADDR_W-1:0] req_target,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_taken,
  output logic              resp_err,
  output logic [ADDR_W-1:0] resp_target
);

  // state  | meaning
  // S_IDLE | ready for a request; resolves at once when flags are settled
  // S_WAIT | request held, waiting for flags_pending to drop (bounded)
  // S_RESP | result presented, held until resp_ready

  localparam int CNT_W = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [3:0]        held_cond;
  logic [ADDR_W-1:0] held_target;
  logic [3:0]        eff;

  // A flag write landing this cycle must win over the stale register value.
  assign eff       = status_load ? status_in : status;
  assign req_ready = rst && (state == S_IDLE);

  function automatic logic cond_true(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, r;
    {n, z, c, v} = f;
    case (cond)
      4'd0:    r = z;
      4'd1:    r = !z;
      4'd2:    r = c;
      4'd3:    r = !c;
      4'd4:    r = n;
      4'd5:    r = !n;
      4'd6:    r = v;
      4'd7:    r = !v;
      4'd8:    r = c && !z;
      4'd9:    r = !c || z;
      4'd10:   r = (n == v);
      4'd11:   r = (n != v);
      4'd12:   r = !z && (n == v);
      4'd13:   r = z || (n != v);
      4'd14:   r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      held_cond   <= '0;
      held_target <= '0;
      resp_valid  <= 1'b0;
      resp_taken  <= 1'b0;
      resp_err    <= 1'b0;
      resp_target <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            held_cond   <= req_cond;
            held_target <= req_target;
            if (!flags_pending) begin
              resp_taken  <= cond_true(req_cond, eff);
              resp_target <= req_target;
              resp_err    <= 1'b0;
              resp_valid  <= 1'b1;
              state       <= S_RESP;
            end else begin
              wait_cnt <= '0;
              state    <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!flags_pending) begin
            resp_taken  <= cond_true(held_cond, eff);
            resp_target <= held_target;
            resp_err    <= 1'b0;
            resp_valid  <= 1'b1;
            state       <= S_RESP;
          end else if (wait_cnt == CNT_LAST) begin
            // Flags never settled: report an error and never claim taken.
            resp_taken  <= 1'b0;
            resp_target <= held_target;
            resp_err    <= 1'b1;
            resp_valid  <= 1'b1;
            state       <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_cond_unit.sv
// Bench for branch_cond_unit: directed vector table, full cond/flag sweep,
// wait/timeout/reset sequences and randomized transactions against a reference.
module tb_branch_cond_unit;
  localparam int ADDR_W   = 16;
  localparam int WAIT_MAX = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        status;
  logic              status_load;
  logic [3:0]        status_in;
  logic              flags_pending;
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_cond;
  logic [ADDR_W-1:0] req_target;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_taken;
  logic              resp_err;
  logic [ADDR_W-1:0] resp_target;

  int checks = 0;
  int errors = 0;

  branch_cond_unit #(.ADDR_W(ADDR_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst), .status(status), .status_load(status_load),
    .status_in(status_in), .flags_pending(flags_pending),
    .req_valid(req_valid), .req_ready(req_ready), .req_cond(req_cond),
    .req_target(req_target), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_taken(resp_taken), .resp_err(resp_err), .resp_target(resp_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  st;
    logic        ld;
    logic [3:0]  si;
    logic [3:0]  cond;
    logic [15:0] tgt;
    logic        exp;
  } vec_t;

  vec_t vecs[12];

  // Even codes are the base predicates; each odd code is the inverse of its pair.
  function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    logic [7:0] base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    base[0] = z;
    base[1] = c;
    base[2] = n;
    base[3] = v;
    base[4] = c & ~z;
    base[5] = ~(n ^ v);
    base[6] = ~z & ~(n ^ v);
    base[7] = 1'b1;
    return base[cc[3:1]] ^ cc[0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request; nw = cycles (counting the accept cycle) with flags_pending=1.
  task automatic txn(input logic [3:0] cond, input logic [15:0] tgt, input int nw,
                     input int hold, input bit fixed, input logic [3:0] st_f,
                     input logic ld_f, input logic [3:0] si_f, input int exp_fixed);
    int   last;
    bit   to;
    logic exp_taken;
    logic [3:0] e;
    last = (nw > WAIT_MAX) ? WAIT_MAX : nw;
    to = (nw > WAIT_MAX);
    exp_taken = 1'b0;
    for (int c = 0; c <= last; c++) begin
      if (fixed) begin
        status = st_f; status_load = ld_f; status_in = si_f;
      end else begin
        status = 4'($urandom); status_load = 1'($urandom); status_in = 4'($urandom);
      end
      flags_pending = (c < nw);
      resp_ready = 1'($urandom);
      if (c == 0) begin
        req_valid = 1'b1; req_cond = cond; req_target = tgt;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
      end else begin
        req_valid = 1'($urandom); req_cond = 4'($urandom); req_target = 16'($urandom);
        chk("req_ready_wait", 32'(req_ready), 32'd0);
      end
      if (c == last && !to) begin
        e = status_load ? status_in : status;
        exp_taken = ref_cond(cond, e);
      end
      tick();
      if (c < last) chk("resp_valid_early", 32'(resp_valid), 32'd0);
    end
    if (exp_fixed >= 0 && !to) chk("taken_directed", 32'(resp_taken), 32'(exp_fixed));
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("resp_taken", 32'(resp_taken), 32'(to ? 1'b0 : exp_taken));
    chk("resp_err", 32'(resp_err), 32'(to));
    chk("resp_target", 32'(resp_target), 32'(tgt));
    for (int h = 0; h < hold; h++) begin
      resp_ready = 1'b0;
      status = 4'($urandom); status_load = 1'($urandom); status_in = 4'($urandom);
      flags_pending = 1'($urandom);
      req_valid = 1'($urandom); req_cond = 4'($urandom);
      chk("req_ready_resp", 32'(req_ready), 32'd0);
      tick();
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_taken", 32'(resp_taken), 32'(to ? 1'b0 : exp_taken));
      chk("hold_target", 32'(resp_target), 32'(tgt));
    end
    resp_ready = 1'b1;
    req_valid = 1'($urandom);
    flags_pending = 1'b0;
    tick();
    chk("release_valid", 32'(resp_valid), 32'd0);
    chk("release_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
    resp_ready = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{4'b0100, 1'b0, 4'b0000, 4'd0,  16'h1234, 1'b1};
    vecs[1]  = '{4'b0000, 1'b1, 4'b1000, 4'd4,  16'h2000, 1'b1};
    vecs[2]  = '{4'b0000, 1'b0, 4'b0000, 4'd0,  16'h0001, 1'b0};
    vecs[3]  = '{4'b0010, 1'b0, 4'b0000, 4'd8,  16'h3000, 1'b1};
    vecs[4]  = '{4'b0110, 1'b0, 4'b0000, 4'd8,  16'h3001, 1'b0};
    vecs[5]  = '{4'b1000, 1'b0, 4'b0000, 4'd10, 16'h4000, 1'b0};
    vecs[6]  = '{4'b1001, 1'b0, 4'b0000, 4'd10, 16'h4001, 1'b1};
    vecs[7]  = '{4'b0000, 1'b0, 4'b0000, 4'd13, 16'h5000, 1'b0};
    vecs[8]  = '{4'b1111, 1'b1, 4'b0000, 4'd0,  16'h6000, 1'b0};
    vecs[9]  = '{4'b0100, 1'b1, 4'b0000, 4'd1,  16'h7000, 1'b1};
    vecs[10] = '{4'b0000, 1'b0, 4'b0000, 4'd14, 16'hffff, 1'b1};
    vecs[11] = '{4'b1111, 1'b0, 4'b0000, 4'd15, 16'h8000, 1'b0};

    rst = 1'b0;
    status = '0; status_load = 1'b0; status_in = '0; flags_pending = 1'b0;
    req_valid = 1'b0; req_cond = '0; req_target = '0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_taken", 32'(resp_taken), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_target", 32'(resp_target), 32'd0);
    rst = 1'b1;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    foreach (vecs[i])
      txn(vecs[i].cond, vecs[i].tgt, 0, 0, 1'b1, vecs[i].st, vecs[i].ld, vecs[i].si,
          int'(vecs[i].exp));

    // Wait three cycles past accept, then resolve with flags loaded that cycle.
    txn(4'd10, 16'hbeef, 4, 0, 1'b1, 4'b0000, 1'b1, 4'b1001, 1);
    // Limit boundary: settling on the last allowed cycle vs. one cycle too late.
    txn(4'd14, 16'h0a0a, WAIT_MAX, 0, 1'b1, 4'b0000, 1'b0, 4'b0000, 1);
    txn(4'd14, 16'h0b0b, WAIT_MAX + 1, 0, 1'b1, 4'b0100, 1'b0, 4'b0000, -1);
    txn(4'd14, 16'h0f0f, WAIT_MAX + 6, 2, 1'b1, 4'b0100, 1'b0, 4'b0000, -1);
    txn(4'd0, 16'h5555, 0, 4, 1'b0, 4'b0000, 1'b0, 4'b0000, -1);

    // Reset in the middle of a wait drops the held request.
    req_valid = 1'b1; req_cond = 4'd14; req_target = 16'h7777; flags_pending = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("midwait_rst_valid", 32'(resp_valid), 32'd0);
    chk("midwait_rst_ready", 32'(req_ready), 32'd0);
    tick();
    chk("midwait_rst_ready2", 32'(req_ready), 32'd0);
    flags_pending = 1'b0;
    rst = 1'b1;
    #1;
    chk("midwait_rel_ready", 32'(req_ready), 32'd1);
    tick();
    chk("midwait_no_stale", 32'(resp_valid), 32'd0);
    txn(4'd1, 16'h1111, 2, 1, 1'b0, 4'b0000, 1'b0, 4'b0000, -1);

    // Reset while a response is pending clears it immediately.
    req_valid = 1'b1; req_cond = 4'd14; req_target = 16'h9999; flags_pending = 1'b0;
    tick();
    req_valid = 1'b0;
    chk("midresp_valid", 32'(resp_valid), 32'd1);
    rst = 1'b0;
    #1;
    chk("midresp_rst_valid", 32'(resp_valid), 32'd0);
    chk("midresp_rst_target", 32'(resp_target), 32'd0);
    chk("midresp_rst_taken", 32'(resp_taken), 32'd0);
    rst = 1'b1;
    #1;

    for (int cc = 0; cc < 16; cc++)
      for (int f = 0; f < 16; f++)
        txn(4'(cc), 16'($urandom), 0, 0, 1'b1, 4'(f), 1'b0, 4'b0000, -1);

    for (int k = 0; k < 200; k++) begin
      int nw;
      nw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WAIT_MAX + 3))
                                       : int'($urandom_range(0, 3));
      txn(4'($urandom), 16'($urandom), nw, int'($urandom_range(0, 3)), 1'b0,
          4'b0000, 1'b0, 4'b0000, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
